mux_serial_port: RTL



---
 rtl/mux_serial_port.sv | 363 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mux_serial_port.sv
// -----------------------------------------------------------------------------
// mux_serial_port
//   Memory-mapped 8N1 serial port (MUX channel 0) for the CPU6 system bus.
//   A status register lives at BASE_ADDR and a data register at BASE_ADDR+1.
//   Writes to the data register queue bytes in a small TX FIFO that feeds an
//   8N1 transmitter. A single-byte-buffered receiver samples rxd through a
//   2-flop synchronizer and reports ready / overrun / framing-error flags.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   address     in   [15:0] CPU address bus
//   write_en    in   CPU write strobe
//   read_en     in   CPU read-capture strobe
//   write_data  in   [7:0] CPU data-out bus
//   read_data   out  [7:0] combinational register read data (0 when no hit)
//   hit         out  address decodes to the status or data register
//   txd         out  serial transmit line, idles high
//   rxd         in   serial receive line, asynchronous to clock
//   irq         out  mirrors rx_ready
//
// Status register bits: 0 rx_ready, 1 tx_not_full, 2 overrun, 3 tx_idle,
// 4 frame_err, 7:5 zero. Writing 1 to bit 2 / bit 4 clears overrun /
// frame_err.
// -----------------------------------------------------------------------------
module mux_serial_port #(
    parameter logic [15:0] BASE_ADDR    = 16'hF200,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          TX_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [7:0]  write_data,
    output logic [7:0]  read_data,
    output logic        hit,
    output logic        txd,
    input  logic        rxd,
    output logic        irq
);

    localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd1;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam int          PTR_W     = $clog2(TX_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(TX_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic sel_stat;
    logic sel_data;

    assign sel_stat = (address == BASE_ADDR);
    assign sel_data = (address == DATA_ADDR);
    assign hit      = sel_stat | sel_data;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             tx_push;
    logic             tx_pop;
    logic [7:0]       fifo_head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_head  = fifo_mem[rd_ptr_q];
    // Fullness is judged on the pre-edge count, so a write that lands while
    // full is dropped even if the transmitter pops on the same edge.
    assign tx_push    = write_en & sel_data & ~fifo_full;

    always_ff @(posedge clock) begin
        if (tx_push) begin
            fifo_mem[wr_ptr_q] <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (tx_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (tx_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({tx_push, tx_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_head;
                    txd_d      = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        // Shifter bit 0 is always the bit currently on the line.
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_head;
                        txd_d      = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: begin
                txd_d      = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    assign txd = txd_q;

    // ------------------------------------------------------------------
    // RX synchronizer and FSM
    // ------------------------------------------------------------------
    logic        rx_meta_q;
    logic        rxs_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_done_ok;
    logic        rx_done_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= rxd;
            rxs_q      <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_done_ok  = 1'b0;
        rx_done_err = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rxs_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: confirms the start bit and aligns later
                // samples to mid-bit.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rxs_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bit_d   = '0;
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxs_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d    = '0;
                    rx_state_d  = RX_IDLE;
                    rx_done_ok  = rxs_q;
                    rx_done_err = ~rxs_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX flags and data buffer
    // ------------------------------------------------------------------
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_ready_q, rx_ready_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic       rd_clear;
    logic       stat_wr;

    assign rd_clear = read_en & sel_data;
    assign stat_wr  = write_en & sel_stat;

    // In every case a set event takes priority over a clear on the same edge.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_ready_d  = rx_ready_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (rx_done_ok) begin
            rx_data_d  = rx_shift_q;
            rx_ready_d = 1'b1;
        end else if (rd_clear) begin
            rx_ready_d = 1'b0;
        end
        if (rx_done_ok && rx_ready_q && !rd_clear) begin
            overrun_d = 1'b1;
        end else if (stat_wr && write_data[2]) begin
            overrun_d = 1'b0;
        end
        if (rx_done_err) begin
            frame_err_d = 1'b1;
        end else if (stat_wr && write_data[4]) begin
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_data_q   <= rx_data_d;
            rx_ready_q  <= rx_ready_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic       tx_idle;
    logic [7:0] status;

    assign tx_idle = fifo_empty & (tx_state_q == TX_IDLE);
    assign status  = {3'b000, frame_err_q, tx_idle, overrun_q, ~fifo_full, rx_ready_q};

    always_comb begin
        read_data = 8'h00;
        if (sel_stat) begin
            read_data = status;
        end else if (sel_data) begin
            read_data = rx_data_q;
        end
    end

    assign irq = rx_ready_q;

endmodule
